// File: rtl/ysyx_2022040010_lsu_if.sv
// Data-memory bus between the LSU (master) and data memory (slave).
// The request is held stable until valid&ready. The response arrives later on resp_valid.
interface ysyx_2022040010_lsu_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic                  dmem_we;
  logic [ADDR_W-1:0]     dmem_addr;
  logic [DATA_W/8-1:0]   dmem_wstrb;
  logic [DATA_W-1:0]     dmem_wdata;
  logic                  dmem_resp_valid;
  logic [DATA_W-1:0]     dmem_resp_data;

  modport master (
    output dmem_req_valid, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_data
  );

  modport slave (
    input  dmem_req_valid, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_data
  );
endinterface

// File: rtl/ysyx_2022040010_lsu.sv
// LSU: one outstanding data-memory access. Stall is held from the request cycle until the response; best case is 3 stall cycles.
// Each withheld ready or resp_valid cycle adds one stall cycle. Misaligned requests only pulse misalign_err.
module ysyx_2022040010_lsu #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  ysyx_2022040010_lsu_if.master dmem,
  output logic [DATA_W-1:0]   dsram_rdata,
  output logic [DATA_W/8-1:0] dsram_sel,
  output logic                stallreq_lsu,
  output logic                misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t            state;
  logic              misaligned;
  logic [2:0]        off;
  logic [7:0]        sel;
  logic [63:0]       wdata_rep;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [7:0]        lat_sel;
  logic [63:0]       lat_wdata;
  logic              req_vld_q;

  assign off = req_addr[2:0];

  always_comb begin
    misaligned = 1'b0;
    sel        = 8'hFF;
    wdata_rep  = req_wdata;
    case (req_size)
      2'd0: begin
        sel       = 8'h01 << off;
        wdata_rep = {8{req_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = off[0];
        sel        = 8'h03 << off;
        wdata_rep  = {4{req_wdata[15:0]}};
      end
      2'd2: begin
        misaligned = |off[1:0];
        sel        = 8'h0F << off;
        wdata_rep  = {2{req_wdata[31:0]}};
      end
      default: misaligned = |off;
    endcase
  end

  // Stall rises combinationally in the request cycle so EX holds the instruction.
  assign stallreq_lsu = (state == REQ) || (state == RESP) ||
                        ((state == IDLE) && req_valid && !misaligned);

  assign dmem.dmem_req_valid = req_vld_q;
  assign dmem.dmem_we        = lat_we;
  assign dmem.dmem_addr      = lat_addr;
  assign dmem.dmem_wstrb     = lat_we ? lat_sel : 8'h00;
  assign dmem.dmem_wdata     = lat_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_vld_q    <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_sel      <= 8'h00;
      lat_wdata    <= 64'h0;
      dsram_rdata  <= '0;
      dsram_sel    <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && misaligned) begin
            misalign_err <= 1'b1;
          end else if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
            lat_sel   <= sel;
            lat_wdata <= wdata_rep;
            req_vld_q <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (dmem.dmem_req_ready) begin
            req_vld_q <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          // Stores only report which bytes were written; read data is kept.
          if (dmem.dmem_resp_valid) begin
            if (!lat_we) dsram_rdata <= dmem.dmem_resp_data;
            dsram_sel <= lat_sel;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_lsu.sv
// Directed bench for the LSU: reset, back-to-back loads, store strobes, backpressure, misalignment.
module tb_ysyx_2022040010_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [63:0] dsram_rdata;
  logic [7:0]  dsram_sel;
  logic        stallreq_lsu, misalign_err;

  int total = 0;
  int bad   = 0;

  ysyx_2022040010_lsu_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  ysyx_2022040010_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .dmem         (bus.master),
    .dsram_rdata  (dsram_rdata),
    .dsram_sel    (dsram_sel),
    .stallreq_lsu (stallreq_lsu),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1. Cycle 0 is the request cycle; ready is withheld
  // rdy_wait cycles, resp_valid rsp_wait cycles after acceptance.
  task automatic txn(input string tag, input logic we, input logic [1:0] size,
                     input logic [63:0] addr, input logic [63:0] wdata,
                     input int rdy_wait, input int rsp_wait, input bit early,
                     input logic [63:0] rdata, input logic [63:0] exp_addr,
                     input logic [7:0] exp_wstrb, input logic [63:0] exp_wdata,
                     input logic [63:0] exp_rdata, input logic [7:0] exp_sel,
                     input int exp_stall);
    int  last;
    int  stall_n;
    int  hs_n;
    bit  bus_bad;
    last    = rdy_wait + rsp_wait + 3;
    stall_n = 0;
    hs_n    = 0;
    bus_bad = 1'b0;
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    bus.dmem_resp_data = rdata;
    for (int c = 0; c <= last; c++) begin
      bus.dmem_req_ready  = (c >= rdy_wait + 1);
      bus.dmem_resp_valid = (c == rdy_wait + 2 + rsp_wait) || (early && c == rdy_wait + 1);
      @(negedge clk);
      if (stallreq_lsu) stall_n++;
      if (bus.dmem_req_valid && bus.dmem_req_ready) hs_n++;
      if (c >= 1 && c <= rdy_wait + 1) begin
        if (!(bus.dmem_req_valid === 1'b1 && bus.dmem_we === we &&
              bus.dmem_addr === exp_addr && bus.dmem_wstrb === exp_wstrb &&
              bus.dmem_wdata === exp_wdata))
          bus_bad = 1'b1;
      end
      if (c == last) begin
        chk({tag, "_rdata"}, dsram_rdata, exp_rdata);
        chk({tag, "_sel"}, 64'(dsram_sel), 64'(exp_sel));
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; bus.dmem_req_ready = 1'b0; bus.dmem_resp_valid = 1'b0;
    chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(exp_stall));
    chk({tag, "_handshakes"}, 64'(hs_n), 64'd1);
    chk({tag, "_bus_req"}, 64'(bus_bad), 64'd0);
    chk({tag, "_addr_hold"}, bus.dmem_addr, exp_addr);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
    bus.dmem_req_ready = 1'b0; bus.dmem_resp_valid = 1'b0; bus.dmem_resp_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", 64'(stallreq_lsu), 64'd0);
    chk("rst_req_valid", 64'(bus.dmem_req_valid), 64'd0);
    chk("rst_rdata", dsram_rdata, 64'd0);
    chk("rst_sel", 64'(dsram_sel), 64'd0);
    chk("rst_misalign", 64'(misalign_err), 64'd0);
    @(posedge clk); #1;

    txn("ld", 1'b0, 2'd3, 64'h8000_0008, 64'h0, 0, 0, 1'b1, 64'h1122_3344_5566_7788,
        64'h8000_0008, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 8'hFF, 3);
    txn("lb", 1'b0, 2'd0, 64'h8000_0013, 64'h0, 0, 0, 1'b0, 64'hA5A5_5A5A_0102_0304,
        64'h8000_0010, 8'h00, 64'h0, 64'hA5A5_5A5A_0102_0304, 8'h08, 3);
    txn("sh", 1'b1, 2'd1, 64'h8000_0106, 64'h1234_5678_9999_ABCD, 0, 0, 1'b0,
        64'hDEAD_BEEF_DEAD_BEEF, 64'h8000_0100, 8'hC0, 64'hABCD_ABCD_ABCD_ABCD,
        64'hA5A5_5A5A_0102_0304, 8'hC0, 3);
    txn("lw_bp", 1'b0, 2'd2, 64'h8000_0204, 64'h0, 4, 2, 1'b0, 64'h0F0E_0D0C_0B0A_0908,
        64'h8000_0200, 8'h00, 64'h0, 64'h0F0E_0D0C_0B0A_0908, 8'hF0, 9);

    // Misaligned word load.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 64'h8000_0002;
    bus.dmem_req_ready = 1'b1;
    @(negedge clk);
    chk("mis_stall0", 64'(stallreq_lsu), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mis_err", 64'(misalign_err), 64'd1);
    chk("mis_req_valid", 64'(bus.dmem_req_valid), 64'd0);
    chk("mis_stall1", 64'(stallreq_lsu), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_err_pulse", 64'(misalign_err), 64'd0);
    chk("mis_req_valid2", 64'(bus.dmem_req_valid), 64'd0);
    @(posedge clk); #1;

    // Reset during RESP, then a stale response.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'h8000_0300;
    bus.dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b0; bus.dmem_req_ready = 1'b0;
    @(negedge clk);
    chk("mid_resp_stall", 64'(stallreq_lsu), 64'd1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.dmem_resp_valid = 1'b1; bus.dmem_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("rr_stall", 64'(stallreq_lsu), 64'd0);
    chk("rr_req_valid", 64'(bus.dmem_req_valid), 64'd0);
    chk("rr_addr", bus.dmem_addr, 64'd0);
    chk("rr_rdata", dsram_rdata, 64'd0);
    chk("rr_sel", 64'(dsram_sel), 64'd0);
    chk("rr_misalign", 64'(misalign_err), 64'd0);
    @(posedge clk); #1;
    bus.dmem_resp_valid = 1'b0;
    @(negedge clk);
    chk("rr_rdata_after", dsram_rdata, 64'd0);
    chk("rr_stall_after", 64'(stallreq_lsu), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_2022040010_lsu.md
Name: ysyx_2022040010_lsu

Overview:
- Load/store unit between the EX and MEM stages of the ysyx_2022040010 pipeline.
- Takes one data-memory request per instruction from EX and issues it on a valid/ready data bus, with byte strobes and lane replication.
- Raises a stall request until the bus completes. Presents the captured 64-bit read word and the byte-select vector to the MEM stage, which performs load extraction and extension.
- At most one outstanding transaction; no buffering beyond one request.

Parameters:
- ADDR_W, 64, width of request and bus address.
- DATA_W, 64, data bus width; fixed at 64, strobe width DATA_W/8.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  EX presents a memory instruction; held high while EX is stalled.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  64  store data, right-aligned.
- dmem_req_valid  output  1  bus request valid.
- dmem_req_ready  input  1  bus accepts the request.
- dmem_we  output  1  bus write enable.
- dmem_addr  output  ADDR_W  req_addr with bits [2:0] cleared.
- dmem_wstrb  output  8  byte write strobes; 0 for loads.
- dmem_wdata  output  64  lane-replicated store data.
- dmem_resp_valid  input  1  read data / write ack valid.
- dmem_resp_data  input  64  read data; ignored for stores.
- dsram_rdata  output  64  captured read word to MEM.
- dsram_sel  output  8  byte-select of the captured access.
- stallreq_lsu  output  1  stall request to the stall controller.
- misalign_err  output  1  one-cycle pulse for a misaligned request.

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - State = IDLE.
  - dsram_rdata = 0, dsram_sel = 0, misalign_err = 0, dmem_req_valid = 0, latched request fields = 0.
  - A response arriving after reset for a pre-reset request is ignored (state is IDLE).
- Alignment rule: misaligned if size 1 and addr[0] != 0; size 2 and addr[1:0] != 0; size 3 and addr[2:0] != 0.
- Strobe (sel), from addr[2:0] = o:
  - byte 8'h01<<o
  - half 8'h03<<o
  - word 8'h0F<<o
  - double 8'hFF
- wdata replication:
  - byte: wdata[7:0] x8
  - half: wdata[15:0] x4
  - word: wdata[31:0] x2
  - double: as is
- States:
  - IDLE:
    - If req_valid and misaligned: misalign_err = 1 (registered, visible next cycle for one cycle); stay in IDLE; stallreq_lsu = 0; no bus activity.
    - If req_valid and aligned: latch we, addr, sel, replicated wdata; go to REQ. stallreq_lsu = 1 combinationally in this same cycle.
    - Otherwise stallreq_lsu = 0.
  - REQ:
    - dmem_req_valid = 1; dmem_* driven from latched fields, stable until handshake.
    - On dmem_req_valid & dmem_req_ready go to RESP.
    - stallreq_lsu = 1.
  - RESP:
    - dmem_req_valid = 0, stallreq_lsu = 1.
    - On dmem_resp_valid: if load, dsram_rdata <= dmem_resp_data and dsram_sel <= latched sel; if store, dsram_rdata unchanged and dsram_sel <= latched sel. Then go to DONE.
    - A response in the same cycle as the REQ handshake is not accepted; minimum latency is 1 cycle after acceptance.
  - DONE:
    - stallreq_lsu = 0, so the pipeline advances at this edge. req_valid in DONE belongs to the completed instruction and is ignored. Next state IDLE.
- Latency:
  - Best case: request cycle (IDLE) + REQ + RESP + DONE = stall asserted for 3 cycles.
  - Each cycle ready or resp_valid is withheld adds one stall cycle.
- dsram_rdata and dsram_sel hold their values until the next capture. MEM samples them in the cycle after DONE.
- Outside REQ: dmem_req_valid = 0; dmem_addr, dmem_we, dmem_wstrb and dmem_wdata hold the last latched values.

Test Plan:
- Reset mid-RESP:
  - Stimulus: load issued, rst asserted in the RESP cycle, resp_valid = 1 arrives the cycle after rst deassert.
  - Required: IDLE, all outputs 0, response ignored, stallreq_lsu = 0.
- Back-to-back loads, zero-wait bus:
  - Stimulus: ld at 0x80000008 (size 3), then lb at 0x80000013, with ready = 1 always and resp_valid one cycle after accept.
  - Required, first load: dmem_addr = 0x80000008, wstrb = 0, dsram_sel = 8'hFF, stall high 3 cycles.
  - Required, second load: dmem_addr = 0x80000010, dsram_sel = 8'h08.
- Store half:
  - Stimulus: sh at 0x80000106 (size 1), wdata = 0x...ABCD.
  - Required: dmem_wstrb = 8'hC0, dmem_wdata = 0xABCDABCDABCDABCD, dmem_addr = 0x80000100; dsram_rdata unchanged after completion.
- Backpressure:
  - Stimulus: dmem_req_ready low for 4 cycles, then resp_valid delayed 2 cycles.
  - Required: dmem_* stable throughout REQ; stall high for 3 + 4 + 2 = 9 cycles; exactly one handshake.
- Misalign:
  - Stimulus: lw at 0x80000002.
  - Required: misalign_err = 1 for exactly one cycle; no dmem_req_valid; stallreq_lsu stays 0.
